mem_arbiter: RTL and testbench

Arbitrates the single pipelined main memory (memory4c-style, fixed read latency) between the I-cache fill path and the D-cache path. It serves block fills for either side and single-word write-throughs for the D side. For each transaction it sequences the eight word addresses of the block, counts the returning data_valid pulses, and steers each returned word to the owning cache with its word index. It replaces direct cache-FSM-to-memory wiring.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache fill path
// and the D-cache path. Serves 8-word block fills for either side and
// single-word write-throughs for the D side, steering each returned word to
// its owner together with its word index.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no transaction; requests sampled here, memory disabled
// FILL_ISSUE | issuing the eight word reads of the block, returns may land
// FILL_DRAIN | all reads issued, collecting the remaining returns
// WRITE      | single-cycle D write-through, d_done asserted
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LAT         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_word,
    output logic        i_rsp_valid,
    output logic        d_rsp_valid,
    output logic        i_done,
    output logic        d_done,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL_ISSUE = 2'd1,
        FILL_DRAIN = 2'd2,
        WRITE      = 2'd3
    } state_t;

    localparam logic       OWN_I     = 1'b0;
    localparam logic       OWN_D     = 1'b1;
    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

    // With any real read latency the final word cannot arrive before the
    // final issue, so a last-word return only closes a fill from FILL_ISSUE
    // when the memory answers in the same cycle.
    localparam logic LAST_IN_ISSUE = (MEM_LAT < 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [11:0] base_q, base_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  ret_cnt_q, ret_cnt_d;
    logic [14:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        last_winner_q, last_winner_d;

    logic d_wins;
    logic filling;
    logic ret_fire;
    logic fill_last;

    // Address bits below the block (I side) and the byte bit (D side) carry
    // no information for this memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[0]};

    assign rsp_data = mem_rdata;
    assign rsp_word = ret_cnt_q;

    // State and transaction registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            base_q        <= '0;
            issue_cnt_q   <= '0;
            ret_cnt_q     <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            last_winner_q <= OWN_I;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            base_q        <= base_d;
            issue_cnt_q   <= issue_cnt_d;
            ret_cnt_q     <= ret_cnt_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            last_winner_q <= last_winner_d;
        end
    end

    // Arbitration, sequencing, return counting and all outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        base_d        = base_q;
        issue_cnt_d   = issue_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        last_winner_d = last_winner_q;

        i_grant     = 1'b0;
        d_grant     = 1'b0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;

        // On a tie the side that did not win last time goes first.
        if (i_req && d_req) begin
            d_wins = (last_winner_q == OWN_I);
        end else begin
            d_wins = d_req;
        end

        filling   = (state_q == FILL_ISSUE) || (state_q == FILL_DRAIN);
        ret_fire  = filling && mem_data_valid;
        fill_last = ret_fire && (ret_cnt_q == LAST_WORD) &&
                    ((state_q == FILL_DRAIN) || LAST_IN_ISSUE);

        if (state_q != IDLE) begin
            i_grant = (owner_q == OWN_I);
            d_grant = (owner_q == OWN_D);
        end

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d       = d_wins ? OWN_D : OWN_I;
                    last_winner_d = d_wins ? OWN_D : OWN_I;
                    issue_cnt_d   = '0;
                    ret_cnt_d     = '0;
                    if (d_wins && d_wr) begin
                        state_d = WRITE;
                        waddr_d = d_addr[15:1];
                        wdata_d = d_wdata;
                    end else begin
                        state_d = FILL_ISSUE;
                        base_d  = d_wins ? d_addr[15:4] : i_addr[15:4];
                    end
                end
            end
            FILL_ISSUE: begin
                mem_enable  = 1'b1;
                mem_addr    = {base_q, issue_cnt_q, 1'b0};
                issue_cnt_d = issue_cnt_q + 3'd1;
                if (issue_cnt_q == LAST_WORD) begin
                    state_d = FILL_DRAIN;
                end
            end
            FILL_DRAIN: begin
                mem_enable = 1'b0;
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = {waddr_q, 1'b0};
                mem_wdata  = wdata_q;
                d_done     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Returned words go to the current owner in arrival order.
        if (ret_fire) begin
            ret_cnt_d   = ret_cnt_q + 3'd1;
            i_rsp_valid = (owner_q == OWN_I);
            d_rsp_valid = (owner_q == OWN_D);
        end

        if (fill_last) begin
            state_d = IDLE;
            i_done  = (owner_q == OWN_I);
            d_done  = (owner_q == OWN_D);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural fixed-latency memory, a response
// scoreboard fed when requests are driven, table-driven transactions and
// hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int FILL_CYC = 8 + MEM_LAT;
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        i_grant, d_grant;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_word;
    logic        i_rsp_valid, d_rsp_valid;
    logic        i_done, d_done;
    logic [15:0] mem_addr;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic        stray = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.WORDS_PER_BLOCK(8), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .rsp_data(rsp_data), .rsp_word(rsp_word),
        .i_rsp_valid(i_rsp_valid), .d_rsp_valid(d_rsp_valid),
        .i_done(i_done), .d_done(d_done),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    // Memory model: a read issued in one cycle returns MEM_LAT cycles later
    // with data derived from its address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0] pa [MEM_LAT];

    always @(posedge clk) begin
        pv    <= {pv[MEM_LAT-2:0], mem_enable & ~mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end

    assign mem_data_valid = pv[MEM_LAT-1] | stray;
    assign mem_rdata      = pv[MEM_LAT-1] ? memf(pa[MEM_LAT-1]) : 16'hDEAD;

    typedef struct {
        logic        side;
        logic [2:0]  word;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp_q[$];

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic        d_wr;
        logic [15:0] i_addr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        first_d;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fill(input logic side, input logic [15:0] addr);
        rsp_t r;
        for (int w = 0; w < 8; w++) begin
            r.side = side;
            r.word = 3'(w);
            r.data = memf({addr[15:4], 3'(w), 1'b0});
            exp_q.push_back(r);
        end
    endtask

    // Scoreboard consumer: every returned word must match the next expected.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (!rst) begin
            if (i_grant | d_grant) chk("grant_excl", 32'(i_grant & d_grant), 0);
            if (i_rsp_valid | d_rsp_valid) begin
                chk("rsp_excl", 32'(i_rsp_valid & d_rsp_valid), 0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got word %0d data %0h expected none at %0t",
                             rsp_word, rsp_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_side", 32'(d_rsp_valid), 32'(e.side));
                    chk("rsp_word", 32'(rsp_word), 32'(e.word));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_i_grant"}, 32'(i_grant), 0);
        chk({tag, "_d_grant"}, 32'(d_grant), 0);
        chk({tag, "_i_rsp_valid"}, 32'(i_rsp_valid), 0);
        chk({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 0);
        chk({tag, "_i_done"}, 32'(i_done), 0);
        chk({tag, "_d_done"}, 32'(d_done), 0);
        chk({tag, "_mem_enable"}, 32'(mem_enable), 0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_rsp_word"}, 32'(rsp_word), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(mem_rdata));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_wr  = 1'b0;
        #1 check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after the edge that samples the request; walks the
    // transaction cycle by cycle and ends at the negedge of the IDLE cycle.
    task automatic expect_txn(input logic side, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int drop_at);
        int n;
        n = wr ? 1 : FILL_CYC;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk("i_grant", 32'(i_grant), 32'(side == SIDE_I));
            chk("d_grant", 32'(d_grant), 32'(side == SIDE_D));
            if (wr) begin
                chk("wr_mem_enable", 32'(mem_enable), 1);
                chk("wr_mem_wr", 32'(mem_wr), 1);
                chk("wr_mem_addr", 32'(mem_addr), 32'({addr[15:1], 1'b0}));
                chk("wr_mem_wdata", 32'(mem_wdata), 32'(wdata));
                chk("wr_d_done", 32'(d_done), 1);
                chk("wr_i_done", 32'(i_done), 0);
            end else begin
                chk("fill_mem_enable", 32'(mem_enable), 32'(c <= 8));
                chk("fill_mem_wr", 32'(mem_wr), 0);
                if (c <= 8) chk("fill_mem_addr", 32'(mem_addr), 32'({addr[15:4], 3'(c - 1), 1'b0}));
                chk("fill_rsp_valid", 32'(side ? d_rsp_valid : i_rsp_valid), 32'(c > MEM_LAT));
                chk("fill_i_done", 32'(i_done), 32'(side == SIDE_I && c == n));
                chk("fill_d_done", 32'(d_done), 32'(side == SIDE_D && c == n));
            end
            if (c == drop_at || c == n) begin
                if (side) d_req = 1'b0;
                else      i_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("post_i_grant", 32'(i_grant), 0);
        chk("post_d_grant", 32'(d_grant), 0);
        chk("post_mem_enable", 32'(mem_enable), 0);
        chk("post_done", 32'({i_done, d_done}), 0);
    endtask

    vec_t vecs[8];

    initial begin : main
        vec_t v;
        logic first;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h4A58, 16'h1236, 16'h0000, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1236, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0041, 16'hBEEF, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h8F0E, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h7FFF, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'hC004, 16'hFFF2, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h3336, 16'h00A1, 16'h1357, 1'b0};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            first = v.first_d;
            i_addr = v.i_addr;
            d_addr = v.d_addr;
            d_wdata = v.d_wdata;
            d_wr = v.d_wr;
            if (first) begin
                if (!v.d_wr) push_fill(SIDE_D, v.d_addr);
                if (v.i_req) push_fill(SIDE_I, v.i_addr);
            end else begin
                push_fill(SIDE_I, v.i_addr);
                if (v.d_req && !v.d_wr) push_fill(SIDE_D, v.d_addr);
            end
            i_req = v.i_req;
            d_req = v.d_req;
            @(posedge clk); #1;
            if (first) expect_txn(SIDE_D, v.d_wr, v.d_addr, v.d_wdata, 0);
            else       expect_txn(SIDE_I, 1'b0, v.i_addr, 16'h0000, 0);
            if (v.i_req && v.d_req) begin
                @(posedge clk); #1;
                if (first) expect_txn(SIDE_I, 1'b0, v.i_addr, 16'h0000, 0);
                else       expect_txn(SIDE_D, v.d_wr, v.d_addr, v.d_wdata, 0);
            end
        end

        // Continuous contention from reset: D, I, D, I.
        do_reset();
        d_wr = 1'b0;
        d_addr = 16'h2000;
        i_addr = 16'h3000;
        push_fill(SIDE_D, 16'h2000);
        push_fill(SIDE_I, 16'h3000);
        push_fill(SIDE_D, 16'h2010);
        push_fill(SIDE_I, 16'h3010);
        i_req = 1'b1;
        d_req = 1'b1;
        @(posedge clk); #1;
        expect_txn(SIDE_D, 1'b0, 16'h2000, 16'h0000, 0);
        d_addr = 16'h2010;
        d_req = 1'b1;
        @(posedge clk); #1;
        expect_txn(SIDE_I, 1'b0, 16'h3000, 16'h0000, 0);
        i_addr = 16'h3010;
        i_req = 1'b1;
        @(posedge clk); #1;
        expect_txn(SIDE_D, 1'b0, 16'h2010, 16'h0000, 0);
        d_req = 1'b1;
        @(posedge clk); #1;
        expect_txn(SIDE_I, 1'b0, 16'h3010, 16'h0000, 0);
        d_req = 1'b0;

        // Reset in cycle 7 of a D fill, then stray returns in cycles 8-12.
        d_addr = 16'h1236;
        push_fill(SIDE_D, 16'h1236);
        d_req = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        #1;
        rst = 1'b1;
        d_req = 1'b0;
        #1 check_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 1'b1;
        for (int c = 8; c <= 12; c++) begin
            @(negedge clk);
            chk("stray_d_rsp_valid", 32'(d_rsp_valid), 0);
            chk("stray_d_done", 32'(d_done), 0);
            chk("stray_d_grant", 32'(d_grant), 0);
        end
        stray = 1'b0;

        // d_req dropped in cycle 3: fill completes, no new grant follows.
        d_addr = 16'h5554;
        d_wr = 1'b0;
        push_fill(SIDE_D, 16'h5554);
        d_req = 1'b1;
        @(posedge clk); #1;
        expect_txn(SIDE_D, 1'b0, 16'h5554, 16'h0000, 3);
        @(negedge clk);
        chk("no_new_grant", 32'({i_grant, d_grant}), 0);

        repeat (MEM_LAT + 2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
